// File: rtl/fb_pkg.sv
// Framebuffer geometry shared by the arbiter and its address helper,
// plus the memory-port state encoding.
package fb_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned FB_DEPTH = 307200;
  localparam int unsigned ADDR_W   = 19;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StWrite = 2'd2
  } port_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a (column, line) pair to a linear framebuffer address for 640-pixel
// lines; v*640 is built as (v<<9)+(v<<7) so no multiplier is needed.
module fb_addr_calc #(
  parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] h_ext;
  logic [ADDR_W-1:0] v_ext;

  always_comb begin
    h_ext  = ADDR_W'(hcount_i);
    v_ext  = ADDR_W'(vcount_i);
    addr_o = (v_ext << 9) + (v_ext << 7) + h_ext;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch owns slot 0 of every pixel
// period, a held-request writer gets every other free cycle.
module fb_arbiter #(
  parameter int unsigned H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int unsigned ADDR_W   = fb_pkg::ADDR_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              pix_en_i,
  input  logic [9:0]        hcount_i,
  input  logic [9:0]        vcount_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [2:0]        wr_data_i,
  output logic              wr_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [2:0]        mem_wdata_o,
  input  logic [2:0]        mem_rdata_i,
  output logic [2:0]        pix_rgb_o
);

  import fb_pkg::*;

  localparam logic [10:0]     HLim = 11'(H_ACTIVE);
  localparam logic [10:0]     VLim = 11'(V_ACTIVE);
  localparam logic [ADDR_W:0] FbLim = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

  port_state_e       state_q, state_d;
  logic [1:0]        slot_q, slot_d, slot;
  logic              fetch_q, fetch_d;
  logic              visible, wr_in_range;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, pix_addr;
  logic [2:0]        mem_wdata_q, mem_wdata_d;
  logic [2:0]        pix_rgb_q, pix_rgb_d;
  logic              mem_we_q, mem_we_d;

  fb_addr_calc #(
    .ADDR_W(ADDR_W)
  ) u_addr_calc (
    .hcount_i(hcount_i),
    .vcount_i(vcount_i),
    .addr_o  (pix_addr)
  );

  always_comb begin
    state_d     = StIdle;
    slot        = pix_en_i ? 2'd0 : slot_q;
    slot_d      = pix_en_i ? 2'd1 : slot_q + 2'd1;
    fetch_d     = fetch_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    pix_rgb_d   = pix_rgb_q;

    visible     = pix_en_i && ({1'b0, hcount_i} < HLim) && ({1'b0, vcount_i} < VLim);
    wr_in_range = {1'b0, wr_addr_i} < FbLim;

    if (pix_en_i) begin
      fetch_d = visible;
    end

    // A request seen during its own ack cycle is the one just served.
    if (visible) begin
      state_d    = StFetch;
      mem_addr_d = pix_addr;
    end else if (wr_req_i && (state_q != StWrite)) begin
      state_d     = StWrite;
      mem_addr_d  = wr_addr_i;
      mem_wdata_d = wr_data_i;
      mem_we_d    = wr_in_range;
    end

    // Read data for the slot-0 fetch arrives in slot 2; blanking pixels show black.
    if (slot == 2'd2) begin
      pix_rgb_d = fetch_q ? mem_rdata_i : 3'b000;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      slot_q      <= 2'd0;
      fetch_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      pix_rgb_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      fetch_q     <= fetch_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      pix_rgb_q   <= pix_rgb_d;
    end
  end

  assign wr_ack_o    = (state_q == StWrite);
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign pix_rgb_o   = pix_rgb_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter: a synchronous RAM, a pixel-stream and
// writer driver, and a reference of what each pixel and write should produce.
module tb_fb_arbiter;

  localparam int unsigned HAct  = 640;
  localparam int unsigned VAct  = 480;
  localparam int unsigned Depth = HAct * VAct;
  localparam int unsigned AW    = 19;
  localparam int unsigned RstAt = 3000;

  logic          clock = 1'b0;
  logic          reset;
  logic          pix_en;
  logic [9:0]    hcount, vcount;
  logic          wr_req, wr_ack, mem_we;
  logic [AW-1:0] wr_addr, mem_addr;
  logic [2:0]    wr_data, mem_wdata, mem_rdata, pix_rgb;

  always #5 clock = ~clock;

  fb_arbiter #(
    .H_ACTIVE(HAct),
    .V_ACTIVE(VAct),
    .ADDR_W  (AW)
  ) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .pix_en_i   (pix_en),
    .hcount_i   (hcount),
    .vcount_i   (vcount),
    .wr_req_i   (wr_req),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_ack_o   (wr_ack),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .pix_rgb_o  (pix_rgb)
  );

  // Synchronous single-port RAM preloaded with h[2:0] at every v*640+h.
  logic [2:0] ram [Depth];
  initial begin
    for (int i = 0; i < int'(Depth); i++) ram[i] = 3'(i % HAct);
    mem_rdata <= 3'b000;
    forever begin
      @(posedge clock);
      if (mem_addr < AW'(Depth)) mem_rdata <= ram[mem_addr];
      else mem_rdata <= 3'b000;
      if (mem_we && (mem_addr < AW'(Depth))) ram[mem_addr] = mem_wdata;
    end
  end

  typedef struct {logic [AW-1:0] addr; logic [2:0] data;} wreq_t;
  typedef struct {logic [9:0] h; logic [9:0] v; logic chk; logic [2:0] val;} pix_t;
  typedef struct {int unsigned t; logic [2:0] val;} pexp_t;

  logic [2:0]    ref_mem [Depth];
  wreq_t         dir_wr[$];
  pix_t          dir_pix[$];
  pexp_t         pexp[$];

  int            n_checks = 0;
  int            n_fail = 0;
  int unsigned   cyc, next_pix, fetch_chk_cyc, dir_chk_cyc;
  logic          fetch_chk_vld, dir_chk_vld, random_mode, prev_ack, rst_done, pending;
  logic [AW-1:0] fetch_chk_addr, req_addr;
  logic [2:0]    dir_chk_val, req_data, cur_exp;
  int            wait_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_ack"}, 32'(wr_ack), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_pix_rgb"}, 32'(pix_rgb), 0);
  endtask

  task automatic clear_model();
    pexp.delete();
    cur_exp       = 3'b000;
    fetch_chk_vld = 1'b0;
    dir_chk_vld   = 1'b0;
    prev_ack      = 1'b0;
    wait_cnt      = 0;
  endtask

  task automatic mid_write_reset();
    #1 reset = 1'b1;
    #1;
    check_all_zero("rst_mid_write");
    pix_en = 1'b0;
    wr_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cyc += 2;
    clear_model();
    next_pix = cyc + 1 + $urandom_range(0, 3);
    rst_done = 1'b1;
  endtask

  task automatic handle_ack();
    logic in_rng;
    if (wr_ack) begin
      check("ack_adjacent", 32'(prev_ack), 0);
      check("ack_has_req", 32'(pending), 1);
      check("wr_mem_addr", 32'(mem_addr), 32'(req_addr));
      in_rng = req_addr < AW'(Depth);
      check("wr_mem_we", 32'(mem_we), 32'(in_rng));
      if (in_rng) begin
        check("wr_mem_wdata", 32'(mem_wdata), 32'(req_data));
        if (pending) ref_mem[req_addr] = req_data;
      end
      pending  = 1'b0;
      wait_cnt = 0;
    end else begin
      check("we_without_ack", 32'(mem_we), 0);
      if (pending) begin
        wait_cnt++;
        check("wr_wait_bound", 32'(wait_cnt <= 2), 1);
        if (wait_cnt > 2) begin
          pending  = 1'b0;
          wait_cnt = 0;
        end
      end
    end
    prev_ack = wr_ack;
  endtask

  task automatic drive_writer();
    wreq_t       w;
    int unsigned r;
    if (!pending) begin
      if (dir_wr.size() > 0) begin
        w        = dir_wr.pop_front();
        req_addr = w.addr;
        req_data = w.data;
        pending  = 1'b1;
      end else if (random_mode && ($urandom_range(0, 3) != 0)) begin
        r = $urandom_range(0, 9);
        if (r < 8) req_addr = AW'($urandom_range(0, 3) * HAct + $urandom_range(0, HAct - 1));
        else if (r == 8) req_addr = AW'(Depth + $urandom_range(0, 524287 - Depth));
        else req_addr = AW'($urandom_range(0, Depth - 1));
        req_data = 3'($urandom_range(0, 7));
        pending  = 1'b1;
      end
    end
    wr_req  = pending;
    wr_addr = req_addr;
    wr_data = req_data;
  endtask

  task automatic drive_pixel();
    pix_t        p;
    int unsigned a;
    logic        act;
    logic [2:0]  val;
    pix_en = 1'b0;
    if (cyc != next_pix) return;
    if (dir_pix.size() > 0) begin
      p = dir_pix.pop_front();
    end else if (random_mode) begin
      p.h   = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, HAct - 1))
                                         : 10'($urandom_range(HAct, 799));
      p.v   = ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 3))
                                         : 10'($urandom_range(0, 524));
      p.chk = 1'b0;
      p.val = 3'b000;
    end else begin
      p = '{h: 10'd700, v: 10'd500, chk: 1'b0, val: 3'b000};
    end
    pix_en = 1'b1;
    hcount = p.h;
    vcount = p.v;
    // An early strobe pre-empts a pixel whose read data has not been captured yet.
    while ((pexp.size() > 0) && (pexp[pexp.size() - 1].t > cyc)) void'(pexp.pop_back());
    act = (int'(p.h) < int'(HAct)) && (int'(p.v) < int'(VAct));
    a   = p.v * HAct + p.h;
    val = 3'b000;
    if (act) begin
      val            = ref_mem[a];
      fetch_chk_vld  = 1'b1;
      fetch_chk_cyc  = cyc + 1;
      fetch_chk_addr = AW'(a);
    end
    pexp.push_back('{t: cyc + 3, val: val});
    if (p.chk) begin
      dir_chk_vld = 1'b1;
      dir_chk_cyc = cyc + 3;
      dir_chk_val = p.val;
    end
    if (random_mode && ($urandom_range(0, 9) == 0)) next_pix = cyc + $urandom_range(2, 3);
    else next_pix = cyc + 4;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      while ((pexp.size() > 0) && (pexp[0].t == cyc)) begin
        cur_exp = pexp[0].val;
        void'(pexp.pop_front());
      end
      check("pix_rgb", 32'(pix_rgb), 32'(cur_exp));
      if (dir_chk_vld && (dir_chk_cyc == cyc)) begin
        check("pix_directed", 32'(pix_rgb), 32'(dir_chk_val));
        dir_chk_vld = 1'b0;
      end
      if (fetch_chk_vld && (fetch_chk_cyc == cyc)) begin
        check("fetch_addr", 32'(mem_addr), 32'(fetch_chk_addr));
        check("fetch_we", 32'(mem_we), 0);
        check("ack_in_slot0", 32'(wr_ack), 0);
        fetch_chk_vld = 1'b0;
      end
      if (wr_ack && pending && !rst_done && (cyc > RstAt)) mid_write_reset();
      else handle_ack();
      drive_writer();
      drive_pixel();
    end
  endtask

  initial begin
    for (int i = 0; i < int'(Depth); i++) ref_mem[i] = 3'(i % HAct);
    reset       = 1'b1;
    pix_en      = 1'b0;
    hcount      = '0;
    vcount      = '0;
    wr_req      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    req_addr    = '0;
    req_data    = '0;
    pending     = 1'b0;
    rst_done    = 1'b0;
    random_mode = 1'b0;
    cyc         = 0;
    clear_model();
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset    = 1'b0;
    next_pix = 3;

    dir_wr.push_back('{addr: AW'(1000), data: 3'b101});
    dir_wr.push_back('{addr: AW'(307200), data: 3'b111});
    dir_pix.push_back('{h: 10'd700, v: 10'd0, chk: 1'b0, val: 3'b000});
    dir_pix.push_back('{h: 10'd700, v: 10'd0, chk: 1'b0, val: 3'b000});
    dir_pix.push_back('{h: 10'd700, v: 10'd0, chk: 1'b0, val: 3'b000});
    dir_pix.push_back('{h: 10'd640, v: 10'd10, chk: 1'b1, val: 3'b000});
    dir_pix.push_back('{h: 10'd360, v: 10'd1, chk: 1'b1, val: 3'b101});
    dir_pix.push_back('{h: 10'd5, v: 10'd2, chk: 1'b1, val: 3'b101});
    dir_pix.push_back('{h: 10'd639, v: 10'd479, chk: 1'b1, val: 3'b111});
    run(60);

    random_mode = 1'b1;
    run(8000);
    check("mid_write_reset_hit", 32'(rst_done), 1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
